bulk_setter: RTL and testbench
==============================

BULK_SETTER -- requirements
Module: bulk_setter

Interface
REQ-001 SHALL have parameter BITS, default 8: width of the transferred value.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter GAP_BITS, default 4: width of the inter-transfer gap field.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port put_value  input  BITS  local data to enqueue.
REQ-008 SHALL have port put_valid  input  1  local enqueue request.
REQ-009 SHALL have port put_ready  output  1  FIFO can accept; high when occupancy < DEPTH.
REQ-010 SHALL have port gap  input  GAP_BITS  idle cycles to insert after each stream transfer.
REQ-011 SHALL have port value  output  BITS  stream data toward the getter.
REQ-012 SHALL have port valid  output  1  stream data valid.
REQ-013 SHALL have port ready  input  1  getter accepts.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the held output word.
REQ-015 SHALL have port idle  output  1  high when state is IDLE and FIFO is empty.

Function
REQ-016 SHALL enqueue put_value on a rising edge with put_valid=1 and put_ready=1; put_ready depends only on pre-edge occupancy, with no pass-through on a full FIFO.
REQ-017 SHALL drive value and valid from registers, with no combinational path from ready or put_* to value or valid.
REQ-018 SHALL implement states IDLE (valid=0), SEND (valid=1) and GAP (valid=0, counter running).
REQ-019 SHALL, in IDLE with pre-edge FIFO non-empty, pop the head into value and go to SEND at that edge; an item enqueued into an empty FIFO at edge T gives valid=1 after edge T+1.
REQ-020 SHALL hold value and valid stable in SEND while ready=0, with no drop, no reorder and no timeout.
REQ-021 SHALL count a transfer at an edge where valid=1 and ready=1, and SHALL sample gap at that same edge.
REQ-022 SHALL, on a transfer with gap=0, pop the next head and stay in SEND if the pre-edge FIFO is non-empty (1 word/cycle throughput), else go to IDLE.
REQ-023 SHALL, on a transfer with gap=g>0, go to GAP with counter=g, keeping valid=0 for exactly g cycles (valid sampled low at edges T+1..T+g).
REQ-024 SHALL, in GAP, decrement the counter each edge; at counter=1, pop and go to SEND if the FIFO is non-empty, else go to IDLE.
REQ-025 SHALL allow a simultaneous enqueue and pop at one edge, with level unchanged; an enqueue into an empty FIFO at the same edge as a transfer does not feed that edge's pop decision (one bubble).
REQ-026 SHALL wrap FIFO pointers modulo DEPTH and compute occupancy without overflow at DEPTH.

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE, valid=0, value=0, level=0, put_ready=1, idle=1, gap counter=0 and pointers=0, asynchronously.
REQ-028 SHALL discard the held word and all queued words when reset is asserted mid-transfer; no word is presented after release until a new enqueue.
REQ-029 SHALL ignore put_valid and ready while reset_n=0.

Verification
REQ-030 SHALL cover: gap=0, ready=1, enqueue 0x11,0x22,0x33 on consecutive edges -> valid high 3 consecutive cycles with values 0x11,0x22,0x33 in order, first valid one edge after first enqueue.
REQ-031 SHALL cover: DEPTH=4, ready=0, 6 enqueue attempts -> 1 word held at value, level=4, put_ready=0, 6th word refused; after ready=1, 5 words out in order.
REQ-032 SHALL cover: gap=3, ready=1, 2 words queued -> valid low exactly 3 cycles between the two transfers.
REQ-033 SHALL cover: ready toggling 1,0,0,1 while valid=1 -> value unchanged across stalled cycles, each word delivered exactly once.
REQ-034 SHALL cover: reset_n=0 pulse while valid=1 with level=2 -> valid=0, level=0 and idle=1 immediately; nothing output after release.
REQ-035 SHALL cover: simultaneous enqueue and transfer with level=DEPTH-1 -> level stays DEPTH-1 and put_ready stays 1.

Source files
------------

// File: rtl/bulk_setter_if.sv
// Handshake bundle for bulk_setter: local enqueue port plus the outgoing
// valid/ready stream toward the getter.
interface bulk_setter_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] put_value;
    logic            put_valid;
    logic            put_ready;
    logic [BITS-1:0] value;
    logic            valid;
    logic            ready;

    modport master (
        input  put_value,
        input  put_valid,
        input  ready,
        output put_ready,
        output value,
        output valid
    );

    modport slave (
        output put_value,
        output put_valid,
        output ready,
        input  put_ready,
        input  value,
        input  valid
    );
endinterface

// File: rtl/bulk_setter.sv
// Small FIFO feeding a registered valid/ready stream, with a programmable
// number of idle cycles inserted after every accepted stream transfer.
module bulk_setter #(
    parameter int BITS     = 8,
    parameter int DEPTH    = 4,
    parameter int GAP_BITS = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    bulk_setter_if.master              bus,
    input  logic [GAP_BITS-1:0]        gap,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    logic [BITS-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LVL_W-1:0]    count;
    state_t              state;
    logic [GAP_BITS-1:0] gap_cnt;
    logic [BITS-1:0]     value_q;
    logic                valid_q;
    logic                push;
    logic                pop;
    logic                has_data;

    assign bus.put_ready = (count < LVL_W'(DEPTH));
    assign push          = bus.put_valid && bus.put_ready;
    assign has_data      = (count != '0);

    // Pop decisions look only at pre-edge occupancy, so a word written this
    // edge into an empty FIFO cannot be popped until the following edge.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = has_data;
            SEND:    pop = bus.ready && (gap == '0) && has_data;
            GAP:     pop = (gap_cnt == GAP_BITS'(1)) && has_data;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.put_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            value_q <= '0;
            valid_q <= 1'b0;
            gap_cnt <= '0;
        end else begin
            if (pop) begin
                value_q <= mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        valid_q <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ready) begin
                        if (gap != '0) begin
                            gap_cnt <= gap;
                            valid_q <= 1'b0;
                            state   <= GAP;
                        end else if (!pop) begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                GAP: begin
                    // A zero count here is unreachable; treat it like the last gap cycle.
                    if (gap_cnt <= GAP_BITS'(1)) begin
                        gap_cnt <= '0;
                        if (pop) begin
                            valid_q <= 1'b1;
                            state   <= SEND;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_BITS'(1);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    gap_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.value = value_q;
    assign bus.valid = valid_q;
    assign level     = count;
    assign idle      = (state == IDLE) && !has_data;
endmodule

// File: tb/tb_bulk_setter.sv
// Self-checking bench for bulk_setter: directed scenarios followed by random
// traffic, all compared against a queue-based model of the setter.
module tb_bulk_setter;
    localparam int BITS     = 8;
    localparam int DEPTH    = 4;
    localparam int GAP_BITS = 4;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [GAP_BITS-1:0] gap;
    logic [LVL_W-1:0]    level;
    logic                idle;

    bulk_setter_if #(.BITS(BITS)) bus ();

    bulk_setter #(
        .BITS     (BITS),
        .DEPTH    (DEPTH),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master),
        .gap     (gap),
        .level   (level),
        .idle    (idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: words waiting in the queue, the word on offer, and how many
    // more edges must pass before the setter may offer another word.
    logic [BITS-1:0] model_q[$];
    bit              model_valid;
    logic [BITS-1:0] model_value;
    int              model_wait;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_valid = 1'b0;
        model_value = '0;
        model_wait  = 0;
    endtask

    // One clock edge of the setter's rules, using pre-edge occupancy for
    // both acceptance and the pop decision.
    task automatic model_step(input logic pv, input logic [BITS-1:0] pval,
                              input logic rdy, input logic [GAP_BITS-1:0] g);
        int pre_len = model_q.size();
        bit take    = pv && (pre_len < DEPTH);
        bit may_pop = 1'b0;
        if (model_valid) begin
            if (rdy) begin
                model_valid = 1'b0;
                if (g == 0) may_pop = 1'b1;
                else        model_wait = int'(g);
            end
        end else if (model_wait > 1) begin
            model_wait--;
        end else begin
            model_wait = 0;
            may_pop    = 1'b1;
        end
        if (may_pop && pre_len > 0) begin
            model_value = model_q.pop_front();
            model_valid = 1'b1;
        end
        if (take) model_q.push_back(pval);
    endtask

    task automatic check_output();
        check("valid", 32'(bus.valid), 32'(model_valid));
        if (model_valid) check("value", 32'(bus.value), 32'(model_value));
        check("level", 32'(level), 32'(model_q.size()));
        check("put_ready", 32'(bus.put_ready), 32'(model_q.size() < DEPTH));
        check("idle", 32'(idle), 32'(!model_valid && model_wait == 0 && model_q.size() == 0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_value"}, 32'(bus.value), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_idle"}, 32'(idle), 32'd1);
        check({tag, "_put_ready"}, 32'(bus.put_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic pv, input logic [BITS-1:0] pval,
                                  input logic rdy, input logic [GAP_BITS-1:0] g);
        @(negedge clock);
        bus.put_valid = pv;
        bus.put_value = pval;
        bus.ready     = rdy;
        gap           = g;
        model_step(pv, pval, rdy, g);
        @(posedge clock);
        #1;
        check_output();
    endtask

    // Assert reset away from any clock edge, confirm the outputs clear at
    // once, and confirm activity during reset is ignored.
    task automatic reset_pulse(input string tag);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values(tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            bus.put_valid = 1'b1;
            bus.put_value = BITS'($urandom);
            bus.ready     = 1'b1;
            @(posedge clock);
            #1;
            check_reset_values({tag, "_held"});
        end
        @(negedge clock);
        bus.put_valid = 1'b0;
        reset_n       = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.put_valid = 1'b0;
        bus.put_value = '0;
        bus.ready     = 1'b0;
        gap           = '0;
        model_reset();
        @(posedge clock);
        #1;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back stream at full throughput.
        apply_stimulus(1'b1, 8'h11, 1'b1, 4'd0);
        apply_stimulus(1'b1, 8'h22, 1'b1, 4'd0);
        apply_stimulus(1'b1, 8'h33, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        // Fill while stalled; the sixth attempt must be refused.
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, BITS'(8'hA0 + i), 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        // Two words separated by a three-cycle gap.
        apply_stimulus(1'b1, 8'h51, 1'b0, 4'd3);
        apply_stimulus(1'b1, 8'h52, 1'b0, 4'd3);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd3);

        // Ready toggling 1,0,0,1 while words are on offer.
        apply_stimulus(1'b1, 8'h41, 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'h42, 1'b0, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        // Reset while a word is held and two are queued.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, BITS'(8'h61 + i), 1'b0, 4'd0);
        reset_pulse("midreset");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        // Simultaneous enqueue and transfer at DEPTH-1 occupancy.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, BITS'(8'h70 + i), 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'h7F, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        // Random traffic with occasional gaps and one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            logic [GAP_BITS-1:0] g;
            g = ($urandom_range(0, 3) == 0) ? GAP_BITS'($urandom_range(1, 4)) : '0;
            if (i == 200) reset_pulse("randreset");
            apply_stimulus(1'($urandom_range(0, 1)), BITS'($urandom),
                           1'($urandom_range(0, 3) != 0), g);
        end
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
